hack_cpu: RTL and testbench

- Sequential core of the 16-bit Hack CPU. Fetches one instruction per cycle.
- Holds the A and D registers and the program counter.
- Drives the existing Alu16 datapath from the decoded C-instruction fields, and consumes the ALU's out/zr/ng for register writeback, memory write and jump resolution.
- Sits between the instruction ROM / data RAM and Alu16.

---
 rtl/hack_cpu_pkg.sv | 25 ++
 rtl/alu16.sv | 38 +++
 rtl/hack_pc.sv | 37 +++
 rtl/hack_cpu.sv | 106 ++++++++++
 tb/tb_hack_cpu.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hack_cpu_pkg.sv
// ---------------------------------------------------------------------------
// hack_cpu_pkg
// Shared constants for the Hack CPU core (the cpu_defs constant set):
// instruction field bit positions, PC reset value and the default
// WIDTH / PC_W parameter values. Imported by every file of the core.
// ---------------------------------------------------------------------------
package hack_cpu_pkg;

    // Instruction bit positions
    localparam int INST_TYPE = 15;   // 0 = A-instruction, 1 = C-instruction
    localparam int INST_A    = 12;   // ALU y select: 0 = A, 1 = in_m
    localparam int COMP_LSB  = 6;    // zx,nx,zy,ny,f,no occupy [11:6]
    localparam int DEST_A    = 5;
    localparam int DEST_D    = 4;
    localparam int DEST_M    = 3;
    localparam int JUMP_LSB  = 0;    // j1,j2,j3 occupy [2:0]

    // Reset value of the program counter
    localparam int PC_RESET  = 0;

    // Parameter defaults
    localparam int DEF_WIDTH = 16;
    localparam int DEF_PC_W  = 15;

endpackage

// File: rtl/alu16.sv
// ---------------------------------------------------------------------------
// Alu16
// Hack ALU datapath: optional zero/negate of each operand, add or AND,
// optional negate of the result, plus zero and negative flags.
// Ports:
//   i_x, i_y             operands
//   i_zx,i_nx,i_zy,i_ny  operand zero / negate controls
//   i_f                  1 = x+y, 0 = x&y
//   i_no                 negate result
//   o_out                result
//   o_zr                 result == 0
//   o_ng                 result < 0 (two's complement)
// ---------------------------------------------------------------------------
module Alu16 (
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_zx,
    input  logic        i_nx,
    input  logic        i_zy,
    input  logic        i_ny,
    input  logic        i_f,
    input  logic        i_no,
    output logic [15:0] o_out,
    output logic        o_zr,
    output logic        o_ng
);
    logic [15:0] w_x0, w_x1, w_y0, w_y1, w_f;

    assign w_x0  = i_zx ? 16'h0000 : i_x;
    assign w_x1  = i_nx ? ~w_x0 : w_x0;
    assign w_y0  = i_zy ? 16'h0000 : i_y;
    assign w_y1  = i_ny ? ~w_y0 : w_y0;
    assign w_f   = i_f ? (w_x1 + w_y1) : (w_x1 & w_y1);
    assign o_out = i_no ? ~w_f : w_f;
    assign o_zr  = (o_out == 16'h0000);
    assign o_ng  = o_out[15];

endmodule

// File: rtl/hack_pc.sv
// ---------------------------------------------------------------------------
// hack_pc
// Program counter register: load, increment (wrapping at 2^PC_W) or hold.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset (pc <= PC_RESET)
//   i_en     advance this cycle (0 = hold)
//   i_load   when advancing, load i_din instead of incrementing
//   i_din    jump target
//   o_pc     current program counter
// ---------------------------------------------------------------------------
module hack_pc
    import hack_cpu_pkg::*;
#(
    parameter int PC_W = DEF_PC_W
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_en,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_din,
    output logic [PC_W-1:0] o_pc
);
    logic [PC_W-1:0] r_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= PC_W'(PC_RESET);
        end else if (i_en) begin
            // Increment wraps naturally at the PC_W-bit boundary
            r_pc <= i_load ? i_din : (r_pc + 1'b1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/hack_cpu.sv
// ---------------------------------------------------------------------------
// hack_cpu
// Sequential core of the 16-bit Hack CPU, one instruction per clock.
// Holds A, D and (via hack_pc) the program counter; drives Alu16 from the
// decoded C-instruction fields.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   inst       instruction from ROM at address pc
//   in_m       RAM read data at address_m
//   mem_ready  RAM ready (only when CPU_MEM_WAIT_EN is defined)
//   out_m      ALU result / RAM write data
//   write_m    RAM write strobe
//   address_m  RAM address = A[PC_W-1:0]
//   pc         instruction address
// Build option: define CPU_MEM_WAIT_EN to add mem_ready; a C-instruction
// that reads (a=1) or writes (dM=1) memory then stalls until mem_ready=1.
// ---------------------------------------------------------------------------
module hack_cpu
    import hack_cpu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PC_W  = DEF_PC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inst,
    input  logic [WIDTH-1:0] in_m,
`ifdef CPU_MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    output logic [WIDTH-1:0] out_m,
    output logic             write_m,
    output logic [PC_W-1:0]  address_m,
    output logic [PC_W-1:0]  pc
);
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_d;

    logic             w_is_c;
    logic [WIDTH-1:0] w_alu_y;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_zr;
    logic             w_ng;
    logic             w_jump;
    logic             w_commit;

    assign w_is_c  = inst[INST_TYPE];
    assign w_alu_y = inst[INST_A] ? in_m : r_a;

    Alu16 u_alu (
        .i_x   (r_d),
        .i_y   (w_alu_y),
        .i_zx  (inst[COMP_LSB+5]),
        .i_nx  (inst[COMP_LSB+4]),
        .i_zy  (inst[COMP_LSB+3]),
        .i_ny  (inst[COMP_LSB+2]),
        .i_f   (inst[COMP_LSB+1]),
        .i_no  (inst[COMP_LSB]),
        .o_out (w_alu_out),
        .o_zr  (w_zr),
        .o_ng  (w_ng)
    );

    assign w_jump = w_is_c & ((inst[JUMP_LSB+2] & w_ng) |
                              (inst[JUMP_LSB+1] & w_zr) |
                              (inst[JUMP_LSB]   & ~w_ng & ~w_zr));

`ifdef CPU_MEM_WAIT_EN
    logic w_mem_use;
    assign w_mem_use = w_is_c & (inst[INST_A] | inst[DEST_M]);
    assign w_commit  = ~w_mem_use | mem_ready;
`else
    assign w_commit  = 1'b1;
`endif

    // All A reads (ALU y, jump target, address) see the pre-edge A value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_d <= '0;
        end else if (w_commit) begin
            if (!w_is_c) begin
                r_a <= {1'b0, inst[WIDTH-2:0]};
            end else begin
                if (inst[DEST_A]) r_a <= w_alu_out;
                if (inst[DEST_D]) r_d <= w_alu_out;
            end
        end
    end

    hack_pc #(.PC_W(PC_W)) u_pc (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (w_commit),
        .i_load  (w_jump),
        .i_din   (r_a[PC_W-1:0]),
        .o_pc    (pc)
    );

    assign out_m     = w_alu_out;
    // Strobe is gated by reset directly so it drops the moment rst_n falls.
    assign write_m   = rst_n & w_is_c & inst[DEST_M];
    assign address_m = r_a[PC_W-1:0];

endmodule

// File: tb/tb_hack_cpu.sv
// ---------------------------------------------------------------------------
// tb_hack_cpu
// Self-checking bench for hack_cpu: reset, directed vector table, randomized
// instruction stream against an instruction-level reference model, and
// (with CPU_MEM_WAIT_EN) stall and reset-during-stall sequences.
// ---------------------------------------------------------------------------
module tb_hack_cpu;

    logic        clk;
    logic        rst_n;
    logic [15:0] inst;
    logic [15:0] in_m;
    logic [15:0] out_m;
    logic        write_m;
    logic [14:0] address_m;
    logic [14:0] pc;

`ifdef CPU_MEM_WAIT_EN
    logic        mem_ready;
    localparam bit WAIT = 1'b1;
`else
    localparam bit WAIT = 1'b0;
`endif

    hack_cpu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inst      (inst),
        .in_m      (in_m),
`ifdef CPU_MEM_WAIT_EN
        .mem_ready (mem_ready),
`endif
        .out_m     (out_m),
        .write_m   (write_m),
        .address_m (address_m),
        .pc        (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference machine state
    logic [15:0] m_a, m_d;
    logic [14:0] m_pc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Hack computation table by mnemonic meaning; x = D, y = A or M.
    function automatic logic [15:0] ref_comp(input logic [5:0] c, input logic [15:0] x,
                                              input logic [15:0] y);
        case (c)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return 16'd0 - x;
            6'b110011: return 16'd0 - y;
            6'b011111: return x + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return x - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return x + y;
            6'b010011: return x - y;
            6'b000111: return y - x;
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'hxxxx;
        endcase
    endfunction

    logic [5:0] comp_list [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100,
                                   6'b110000, 6'b001101, 6'b110001, 6'b001111,
                                   6'b110011, 6'b011111, 6'b110111, 6'b001110,
                                   6'b110010, 6'b000010, 6'b010011, 6'b000111,
                                   6'b000000, 6'b010101};

    function automatic logic [15:0] ref_out(input logic [15:0] ins, input logic [15:0] m);
        return ref_comp(ins[11:6], m_d, ins[12] ? m : m_a);
    endfunction

    task automatic model_step(input logic [15:0] ins, input logic [15:0] m, input bit rdy);
        logic [15:0] r;
        bit          jmp;
        logic [15:0] old_a;
        if (!ins[15]) begin
            m_a  = {1'b0, ins[14:0]};
            m_pc = m_pc + 15'd1;
        end else begin
            if (WAIT && (ins[12] || ins[3]) && !rdy) return;
            old_a = m_a;
            r   = ref_out(ins, m);
            jmp = (ins[2] && $signed(r) < 0) || (ins[1] && r == 16'd0) ||
                  (ins[0] && $signed(r) > 0);
            m_pc = jmp ? old_a[14:0] : m_pc + 15'd1;
            if (ins[5]) m_a = r;
            if (ins[4]) m_d = r;
        end
    endtask

    // Called with clk low; drives, checks combinational outputs and state,
    // lets one rising edge pass, then returns at the following falling edge.
    task automatic exec(input logic [15:0] ins, input logic [15:0] m, input bit rdy);
        inst = ins;
        in_m = m;
`ifdef CPU_MEM_WAIT_EN
        mem_ready = rdy;
`endif
        #1;
        chk("pc", 32'(pc), 32'(m_pc));
        chk("address_m", 32'(address_m), 32'(m_a[14:0]));
        chk("write_m", 32'(write_m), 32'(ins[15] & ins[3]));
        if (ins[15]) chk("out_m", 32'(out_m), 32'(ref_out(ins, m)));
        @(posedge clk);
        model_step(ins, m, rdy);
        @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] ins;
        logic [15:0] inm;
        logic [14:0] pc;
        logic [14:0] addr;
        logic        wr;
        logic [15:0] out;
        bit          chk_out;
    } vec_t;

    vec_t tv [26];

    initial begin
        // ins      inm      pc       addr     wr  out     chk
        tv[0]  = '{16'h0064, 16'h0000, 15'h0000, 15'h0000, 0, 16'h0000, 0};
        tv[1]  = '{16'hEC10, 16'h0000, 15'h0001, 15'd100,  0, 16'd100,  1};
        tv[2]  = '{16'h0003, 16'h0000, 15'h0002, 15'd100,  0, 16'h0000, 0};
        tv[3]  = '{16'hE090, 16'h0000, 15'h0003, 15'd3,    0, 16'd103,  1};
        tv[4]  = '{16'h00C8, 16'h0000, 15'h0004, 15'd3,    0, 16'h0000, 0};
        tv[5]  = '{16'hE308, 16'h0000, 15'h0005, 15'd200,  1, 16'd103,  1};
        tv[6]  = '{16'h0010, 16'h0000, 15'h0006, 15'd200,  0, 16'h0000, 0};
        tv[7]  = '{16'hFC20, 16'h1234, 15'h0007, 15'h0010, 0, 16'h1234, 1};
        tv[8]  = '{16'h0010, 16'h0000, 15'h0008, 15'h1234, 0, 16'h0000, 0};
        tv[9]  = '{16'hFC28, 16'h1234, 15'h0009, 15'h0010, 1, 16'h1234, 1};
        tv[10] = '{16'hE300, 16'h0000, 15'h000A, 15'h1234, 0, 16'd103,  1};
        tv[11] = '{16'h0010, 16'h0000, 15'h000B, 15'h1234, 0, 16'h0000, 0};
        tv[12] = '{16'hEA90, 16'h0000, 15'h000C, 15'h0010, 0, 16'h0000, 1};
        tv[13] = '{16'hE302, 16'h0000, 15'h000D, 15'h0010, 0, 16'h0000, 1};
        tv[14] = '{16'h0005, 16'h0000, 15'h0010, 15'h0010, 0, 16'h0000, 0};
        tv[15] = '{16'hEC10, 16'h0000, 15'h0011, 15'h0005, 0, 16'h0005, 1};
        tv[16] = '{16'h0010, 16'h0000, 15'h0012, 15'h0005, 0, 16'h0000, 0};
        tv[17] = '{16'hE302, 16'h0000, 15'h0013, 15'h0010, 0, 16'h0005, 1};
        tv[18] = '{16'hEA87, 16'h0000, 15'h0014, 15'h0010, 0, 16'h0000, 1};
        tv[19] = '{16'h7FFF, 16'h0000, 15'h0010, 15'h0010, 0, 16'h0000, 0};
        tv[20] = '{16'hEA87, 16'h0000, 15'h0011, 15'h7FFF, 0, 16'h0000, 1};
        tv[21] = '{16'h0001, 16'h0000, 15'h7FFF, 15'h7FFF, 0, 16'h0000, 0};
        tv[22] = '{16'hE300, 16'h0000, 15'h0000, 15'h0001, 0, 16'h0005, 1};
        tv[23] = '{16'h0030, 16'h0000, 15'h0001, 15'h0001, 0, 16'h0000, 0};
        tv[24] = '{16'hEFE7, 16'h0000, 15'h0002, 15'h0030, 0, 16'h0001, 1};
        tv[25] = '{16'hE300, 16'h0000, 15'h0030, 15'h0001, 0, 16'h0005, 1};

        // Reset with a write instruction presented
        rst_n = 1'b0;
        inst  = 16'hE308;
        in_m  = 16'h0000;
`ifdef CPU_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0;
        #1;
        chk("rst_write_m", 32'(write_m), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_address_m", 32'(address_m), 32'h0);
        chk("rst_write_m_edge", 32'(write_m), 32'h0);
        inst = 16'hE300;   // out_m = D
        #1;
        chk("rst_d", 32'(out_m), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: table constants plus the model inside exec
        for (int i = 0; i < 26; i++) begin
            inst = tv[i].ins;
            in_m = tv[i].inm;
`ifdef CPU_MEM_WAIT_EN
            mem_ready = 1'b1;
`endif
            #1;
            chk($sformatf("tv%0d_pc", i), 32'(pc), 32'(tv[i].pc));
            chk($sformatf("tv%0d_addr", i), 32'(address_m), 32'(tv[i].addr));
            chk($sformatf("tv%0d_wr", i), 32'(write_m), 32'(tv[i].wr));
            if (tv[i].chk_out) chk($sformatf("tv%0d_out", i), 32'(out_m), 32'(tv[i].out));
            exec(tv[i].ins, tv[i].inm, 1'b1);
        end

`ifdef CPU_MEM_WAIT_EN
        // Stall: write D to M[0x40] with two not-ready cycles
        begin
            logic [14:0] pc0;
            logic [15:0] d0;
            exec(16'h0040, 16'h0000, 1'b1);
            pc0 = m_pc;
            d0  = m_d;
            for (int k = 0; k < 3; k++) begin
                inst = 16'hE308; in_m = 16'h0000; mem_ready = (k == 2);
                #1;
                chk($sformatf("stall%0d_pc", k), 32'(pc), 32'(pc0));
                chk($sformatf("stall%0d_addr", k), 32'(address_m), 32'h40);
                chk($sformatf("stall%0d_wr", k), 32'(write_m), 32'h1);
                chk($sformatf("stall%0d_out", k), 32'(out_m), 32'(d0));
                exec(16'hE308, 16'h0000, k == 2);
            end
            #1;
            chk("stall_commit_pc", 32'(pc), 32'(pc0 + 15'd1));
            // Stalled A=M read holds A until ready
            exec(16'hFC20, 16'hBEEF, 1'b0);
            exec(16'hFC20, 16'hBEEF, 1'b1);
            #1;
            chk("stall_read_a", 32'(address_m), 32'(15'h3EEF));
        end
        // Reset in the middle of a stall
        exec(16'h0123, 16'h0000, 1'b1);
        inst = 16'hE308; mem_ready = 1'b0;
        #1;
        chk("pre_rst_wr", 32'(write_m), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midstall_rst_pc", 32'(pc), 32'h0);
        chk("midstall_rst_wr", 32'(write_m), 32'h0);
        chk("midstall_rst_addr", 32'(address_m), 32'h0);
        m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // Randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            logic [15:0] ins;
            logic [15:0] m;
            bit          rdy;
            if ($urandom_range(0, 9) < 3)
                ins = {1'b0, 15'($urandom)};
            else
                ins = {3'b111, 1'($urandom), comp_list[$urandom_range(0, 17)],
                       3'($urandom), 3'($urandom)};
            m   = 16'($urandom);
            rdy = WAIT ? ($urandom_range(0, 3) != 0) : 1'b1;
            exec(ins, m, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
